// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file's single write port. It registers the
// winning write and forwards that in-flight write onto both read ports.
module rf_write_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [5*NREQ-1:0]    i_req_addr,
    input  logic [32*NREQ-1:0]   i_req_data,
    input  logic                 i_hold,
    output logic                 o_rf_we,
    output logic [4:0]           o_rf_wa,
    output logic [31:0]          o_rf_wd,
    input  logic [4:0]           i_rd_ra1,
    input  logic [4:0]           i_rd_ra2,
    input  logic [31:0]          i_rf_rd1,
    input  logic [31:0]          i_rf_rd2,
    output logic [31:0]          o_rd1,
    output logic [31:0]          o_rd2
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic             r_we;
    logic [4:0]       r_wa;
    logic [31:0]      r_wd;

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_cand;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_found;
    logic             w_grant;
    logic [NREQ-1:0]  w_ready;
    logic [4:0]       w_gnt_addr;
    logic [31:0]      w_gnt_data;

    // Search starts one past the last winner; the sum is one bit wider so the
    // wrap can be done by a single conditional subtract instead of a modulo.
    always_comb begin
        w_sum     = '0;
        w_cand    = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NREQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NREQ);
            end
            w_cand = w_sum[PTR_W-1:0];
            if (!w_found && i_req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_grant = w_found && !i_hold && i_reset_n;

    always_comb begin
        w_ready = '0;
        if (w_grant) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign o_req_ready = w_ready;
    assign w_gnt_addr  = i_req_addr[5*int'(w_gnt_idx) +: 5];
    assign w_gnt_data  = i_req_data[32*int'(w_gnt_idx) +: 32];

    // Writes to x0 are still accepted (pointer advances) but never enable the regfile.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr <= PTR_W'(NREQ - 1);
            r_we  <= 1'b0;
            r_wa  <= '0;
            r_wd  <= '0;
        end else if (w_grant) begin
            r_ptr <= w_gnt_idx;
            r_we  <= (w_gnt_addr != 5'd0);
            r_wa  <= w_gnt_addr;
            r_wd  <= w_gnt_data;
        end else begin
            r_we  <= 1'b0;
        end
    end

    assign o_rf_we = r_we;
    assign o_rf_wa = r_wa;
    assign o_rf_wd = r_wd;

    assign o_rd1 = (r_we && (r_wa == i_rd_ra1) && (i_rd_ra1 != 5'd0)) ? r_wd : i_rf_rd1;
    assign o_rd2 = (r_we && (r_wa == i_rd_ra2) && (i_rd_ra2 != 5'd0)) ? r_wd : i_rf_rd2;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with NREQ=2 and a behavioural regfile
// that commits on the edge after the write port is driven.
module tb_rf_write_arbiter;

    localparam int NREQ = 2;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [5*NREQ-1:0] req_addr;
    logic [32*NREQ-1:0] req_data;
    logic              hold;
    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [31:0]       rf_wd;
    logic [4:0]        rd_ra1;
    logic [4:0]        rd_ra2;
    logic [31:0]       rf_rd1;
    logic [31:0]       rf_rd2;
    logic [31:0]       rd1;
    logic [31:0]       rd2;

    logic [31:0]       mem [32];
    int                checks;
    int                errors;

    rf_write_arbiter #(.NREQ(NREQ)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .i_hold      (hold),
        .o_rf_we     (rf_we),
        .o_rf_wa     (rf_wa),
        .o_rf_wd     (rf_wd),
        .i_rd_ra1    (rd_ra1),
        .i_rd_ra2    (rd_ra2),
        .i_rf_rd1    (rf_rd1),
        .i_rf_rd2    (rf_rd2),
        .o_rd1       (rd1),
        .o_rd2       (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile stand-in: x0 is hard-wired to zero, commits on the rising edge.
    always @(posedge clk) begin
        if (rf_we && rf_wa != 5'd0) begin
            mem[rf_wa] <= rf_wd;
        end
    end
    assign rf_rd1 = mem[rd_ra1];
    assign rf_rd2 = mem[rd_ra2];

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [4:0] a0, input logic [31:0] d0,
                                 input logic [4:0] a1, input logic [31:0] d1,
                                 input logic h);
        req_valid = valid;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        hold      = h;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        reset_n = 1'b0;
        rd_ra1  = 5'd0;
        rd_ra2  = 5'd0;
        applyStimulus(2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0);

        // Reset with every requester valid.
        #2;
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_we",    32'(rf_we),     32'h0);
        checkOutput("reset_wa",    32'(rf_wa),     32'h0);
        checkOutput("reset_wd",    rf_wd,          32'h0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        #1;
        checkOutput("post_reset_ready", 32'(req_ready), 32'h1);

        // Contention: grant order 0,1,0,1 with rf_we high every cycle.
        tick();
        checkOutput("cont1_we", 32'(rf_we), 32'h1);
        checkOutput("cont1_wa", 32'(rf_wa), 32'd1);
        checkOutput("cont1_wd", rf_wd, 32'h11);
        checkOutput("cont1_ready", 32'(req_ready), 32'h2);
        tick();
        checkOutput("cont2_we", 32'(rf_we), 32'h1);
        checkOutput("cont2_wa", 32'(rf_wa), 32'd2);
        checkOutput("cont2_wd", rf_wd, 32'h22);
        checkOutput("cont2_ready", 32'(req_ready), 32'h1);
        tick();
        checkOutput("cont3_we", 32'(rf_we), 32'h1);
        checkOutput("cont3_wa", 32'(rf_wa), 32'd1);
        applyStimulus(2'b10, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0);
        #1;
        checkOutput("cont3_ready", 32'(req_ready), 32'h2);
        tick();
        checkOutput("cont4_we", 32'(rf_we), 32'h1);
        checkOutput("cont4_wa", 32'(rf_wa), 32'd2);

        // Single write x5 = DEADBEEF from requester 0.
        rd_ra1 = 5'd5;
        applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0);
        #1;
        checkOutput("single_ready", 32'(req_ready), 32'h1);
        checkOutput("single_rd1_before", rd1, 32'h0);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        checkOutput("single_we", 32'(rf_we), 32'h1);
        checkOutput("single_wa", 32'(rf_wa), 32'd5);
        checkOutput("single_wd", rf_wd, 32'hDEADBEEF);
        checkOutput("single_rd1_fwd", rd1, 32'hDEADBEEF);
        tick();
        checkOutput("single_we_after", 32'(rf_we), 32'h0);
        checkOutput("single_rd1_rf", rd1, 32'hDEADBEEF);
        rd_ra1 = 5'd2;
        #1;
        checkOutput("contention_x2_rf", rd1, 32'h22);

        // x0 write from requester 1 is accepted and discarded.
        rd_ra2 = 5'd0;
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0);
        #1;
        checkOutput("x0_ready", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        checkOutput("x0_we", 32'(rf_we), 32'h0);
        checkOutput("x0_rd2", rd2, 32'h0);

        // Hold right after a grant: the in-flight write still commits.
        applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b0);
        #1;
        checkOutput("hold_pre_ready", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(2'b01, 5'd10, 32'hAA, 5'd0, 32'h0, 1'b1);
        rd_ra1 = 5'd9;
        #1;
        checkOutput("hold_ready0", 32'(req_ready), 32'h0);
        checkOutput("hold_inflight_we", 32'(rf_we), 32'h1);
        checkOutput("hold_inflight_wa", 32'(rf_wa), 32'd9);
        tick();
        checkOutput("hold_we1", 32'(rf_we), 32'h0);
        checkOutput("hold_ready1", 32'(req_ready), 32'h0);
        checkOutput("hold_x9_rf", rd1, 32'h99);
        tick();
        checkOutput("hold_we2", 32'(rf_we), 32'h0);
        checkOutput("hold_ready2", 32'(req_ready), 32'h0);
        tick();
        checkOutput("hold_we3", 32'(rf_we), 32'h0);
        hold = 1'b0;
        #1;
        checkOutput("hold_release_ready", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        checkOutput("hold_grant_we", 32'(rf_we), 32'h1);
        checkOutput("hold_grant_wa", 32'(rf_wa), 32'd10);
        checkOutput("hold_grant_wd", rf_wd, 32'hAA);

        // Same register back-to-back: x7=1 from req0 then x7=2 from req1.
        rd_ra1 = 5'd7;
        applyStimulus(2'b01, 5'd7, 32'd1, 5'd0, 32'h0, 1'b0);
        #1;
        checkOutput("same_ready0", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd7, 32'd2, 1'b0);
        #1;
        checkOutput("same_rd1_first", rd1, 32'd1);
        checkOutput("same_ready1", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        checkOutput("same_rd1_second", rd1, 32'd2);
        tick();
        checkOutput("same_rd1_final", rd1, 32'd2);

        // Reset mid-operation cancels the in-flight write.
        rd_ra1 = 5'd3;
        applyStimulus(2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 1'b0);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        checkOutput("midrst_we_before", 32'(rf_we), 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_we", 32'(rf_we), 32'h0);
        checkOutput("midrst_rd1_nofwd", rd1, 32'h0);
        tick();
        reset_n = 1'b1;
        #1;
        checkOutput("midrst_x3_rf", rd1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port among NREQ writeback requesters (ALU, load unit, multi-cycle unit) using round-robin arbitration with a valid/ready handshake. It registers the winning write and drives the regfile write port one cycle after the grant. It also forwards that in-flight write onto both read ports, so decode never sees a stale value. It sits between the writeback sources and the regfile, and owns we3/wa3/wd3 exclusively.

## Interface
- NREQ, 2: number of writeback requesters; legal range 2–8.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  one-hot grant; the write from requester i is accepted this cycle.
- req_addr  in  5*NREQ  destination register of requester i (slice [5i+4:5i]).
- req_data  in  32*NREQ  write data of requester i (slice [32i+31:32i]).
- hold  in  1  pipeline hold; blocks all grants while high.
- rf_we  out  1  to regfile we3.
- rf_wa  out  5  to regfile wa3.
- rf_wd  out  32  to regfile wd3.
- rd_ra1, rd_ra2  in  5  read addresses, also presented to the regfile.
- rf_rd1, rf_rd2  in  32  raw regfile read data.
- rd1, rd2  out  32  forwarded read data for decode.

## Operation
- **Handshake**
  - Requester i asserts req_valid[i] together with addr and data.
  - It holds all three stable until it sees req_ready[i]=1. The transfer completes on that edge.
  - Requesters never drop req_valid before they are granted.
- **Arbitration**
  - Round-robin over the requesters with req_valid high.
  - Search starts at index ptr+1 (mod NREQ). The first valid index wins.
  - req_ready is combinational from req_valid, ptr and hold, and is at most one-hot.
  - With hold=1, req_ready=0 regardless of req_valid.
- **Pointer**
  - ptr updates to the granted index on each accepting edge.
  - ptr is unchanged when there is no grant.
  - Reset value is NREQ-1, so requester 0 has top priority after reset.
- **Output stage**
  - On each edge, if a grant occurs: rf_wa <= granted addr, rf_wd <= granted data, rf_we <= (granted addr != 0).
  - Otherwise rf_we <= 0. rf_wa and rf_wd hold their values.
- **x0 writes** are accepted (ready asserted, pointer advanced) and discarded (rf_we stays 0).
- **Forwarding**
  - rd1 = rf_wd when rf_we=1 and rf_wa==rd_ra1 and rd_ra1!=0. Otherwise rd1 = rf_rd1. rd2 follows the same rule with rd_ra2.
  - rd_ra=0 always yields rf_rd (the regfile returns 0).
- **Throughput**: one write per cycle sustained. The arbiter never stalls on the regfile side.
- **Multiple writes to one register**: back-to-back writes to the same register from different requesters commit in grant order. The last grant wins.

## Timing
- **Reset values** (while reset_n=0, asynchronously): rf_we=0, rf_wa=0, rf_wd=0, ptr=NREQ-1.
  - req_ready is forced to 0 while reset_n=0.
- **Reset mid-operation**:
  - An in-flight rf_we is cleared immediately, so that write never commits.
  - Requesters that were not granted keep their valid; they are served after reset deasserts.
- **Write latency**
  - Grant at edge E drives the rf_* outputs from E until E+1.
  - The regfile commits at E+1.
- **Read latency**: rd1/rd2 are combinational and have zero latency.
  - During cycle E..E+1 the value comes from forwarding.
  - After E+1 it comes from the regfile.
- **hold timing**
  - Asserting hold in the cycle right after a grant does not cancel the registered write; that write still commits.
  - hold only blocks new grants.
- **Fairness**: with all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.

## Test plan
- **Reset**: reset_n=0 with every req_valid=1.
  - Required: req_ready=0 and rf_we=0.
  - After release, requester 0 is granted first.
- **Single write**: req0 writes x5=0xDEADBEEF at edge E.
  - Required: rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF in cycle E..E+1.
  - rd_ra1=5 gives rd1=0xDEADBEEF in that same cycle, and the regfile holds the value afterwards.
- **Contention**: NREQ=2, both valid continuously (req0 x1=0x11, req1 x2=0x22).
  - Required grant order: 0,1,0,1.
  - Each requester is granted every 2 cycles and rf_we stays high continuously.
- **x0 discard**: req1 writes x0=0xFFFFFFFF.
  - Required: req_ready[1]=1 and rf_we stays 0.
  - rd_ra2=0 gives rd2=0.
- **Hold**: hold=1 for 3 cycles with req0 valid.
  - Required: req_ready=0 and rf_we=0 after the in-flight write drains.
  - Grant occurs in the first cycle with hold=0.
- **Same register back-to-back**: req0 writes x7=1, then req1 writes x7=2 on consecutive grants.
  - Required: rd1 (rd_ra1=7) reads 1, then 2.
  - Final regfile value is 2.
